// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and fetch-entry type for the fetch front end
package fetch_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch FIFO with push, pop and flush
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t din,
  output fetch_entry_t head_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign head_entry = mem[head];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: '0, instr: NOP_INSTR};
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, fetch queue arbitration and redirect handling
module fetch_unit import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic clk,
  input  logic rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic fetch_en,
  input  logic redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic [$clog2(DEPTH):0] queue_count
);
  logic [PC_W-1:0] pc;
  logic push, pop, full, empty;
  fetch_entry_t head;
  assign imem_addr = pc;
  assign out_valid = !empty && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign push = fetch_en && !redirect_valid && (!full || pop);
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  assign out_pc_plus4 = head.pc + 32'd4;
  always_ff @(posedge clk)
    if (!rst_n) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~32'h3;
    else if (push) pc <= pc + 32'd4;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc, imem_instr}),
    .head_entry(head),
    .count(queue_count),
    .full(full),
    .empty(empty)
  );
endmodule
